// File: rtl/synchronizer.sv
// Router control-path glue: latches the packet destination, steers the FSM
// write strobe to the addressed FIFO, returns that FIFO's full flag, drives
// per-port valid flags and issues a soft reset to any port whose data sits
// unread for 30 consecutive cycles.
module synchronizer (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_reg,
    output logic [2:0] wr_en,
    input  logic [1:0] din,
    input  logic       det_addr,
    input  logic       f_0,
    input  logic       f_1,
    input  logic       f_2,
    input  logic       e_0,
    input  logic       e_1,
    input  logic       e_2,
    input  logic       re_0,
    input  logic       re_1,
    input  logic       re_2,
    output logic       fifo_full,
    output logic       valid_out_0,
    output logic       valid_out_1,
    output logic       valid_out_2,
    output logic       soft_rst0,
    output logic       soft_rst1,
    output logic       soft_rst2
);

    localparam logic [4:0] TIMEOUT_LAST = 5'd29;

    logic [1:0] r_addr;
    logic [4:0] r_cnt [3];
    logic [2:0] r_soft_rst;
    logic [2:0] w_valid;
    logic [2:0] w_hold;

    // Destination capture on header detect; reset returns to port 0
    always_ff @(posedge clk) begin
        if (rst)
            r_addr <= 2'b00;
        else if (det_addr)
            r_addr <= din;
    end

    // Steer the write strobe to the addressed FIFO; address 3 writes nowhere
    always_comb begin
        wr_en = 3'b000;
        if (wr_en_reg) begin
            case (r_addr)
                2'b00:   wr_en = 3'b001;
                2'b01:   wr_en = 3'b010;
                2'b10:   wr_en = 3'b100;
                default: wr_en = 3'b000;
            endcase
        end
    end

    // Return the full flag of the addressed FIFO; address 3 never reports full
    always_comb begin
        fifo_full = 1'b0;
        case (r_addr)
            2'b00:   fifo_full = f_0;
            2'b01:   fifo_full = f_1;
            2'b10:   fifo_full = f_2;
            default: fifo_full = 1'b0;
        endcase
    end

    assign w_valid     = ~{e_2, e_1, e_0};
    assign w_hold      = w_valid & ~{re_2, re_1, re_0};
    assign valid_out_0 = w_valid[0];
    assign valid_out_1 = w_valid[1];
    assign valid_out_2 = w_valid[2];

    // Per-port idle timers: pulse soft reset on every 30th consecutive held edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++)
                r_cnt[i] <= 5'd0;
            r_soft_rst <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!w_hold[i]) begin
                    r_cnt[i]      <= 5'd0;
                    r_soft_rst[i] <= 1'b0;
                end else if (r_cnt[i] == TIMEOUT_LAST) begin
                    r_cnt[i]      <= 5'd0;
                    r_soft_rst[i] <= 1'b1;
                end else begin
                    r_cnt[i]      <= r_cnt[i] + 5'd1;
                    r_soft_rst[i] <= 1'b0;
                end
            end
        end
    end

    assign soft_rst0 = r_soft_rst[0];
    assign soft_rst1 = r_soft_rst[1];
    assign soft_rst2 = r_soft_rst[2];

endmodule

// File: tb/tb_synchronizer.sv
// Self-checking bench for synchronizer: directed steps followed by random
// traffic, compared against a run-length reference model.
module tb_synchronizer;

    logic       clk = 1'b0;
    logic       rst, wr_en_reg, det_addr;
    logic [1:0] din;
    logic [2:0] wr_en;
    logic       f_0, f_1, f_2, e_0, e_1, e_2, re_0, re_1, re_2;
    logic       fifo_full, valid_out_0, valid_out_1, valid_out_2;
    logic       soft_rst0, soft_rst1, soft_rst2;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_addr;
    int m_run [3];
    bit m_srst [3];

    synchronizer dut (
        .clk(clk), .rst(rst), .wr_en_reg(wr_en_reg), .wr_en(wr_en), .din(din),
        .det_addr(det_addr), .f_0(f_0), .f_1(f_1), .f_2(f_2),
        .e_0(e_0), .e_1(e_1), .e_2(e_2), .re_0(re_0), .re_1(re_1), .re_2(re_2),
        .fifo_full(fifo_full), .valid_out_0(valid_out_0), .valid_out_1(valid_out_1),
        .valid_out_2(valid_out_2), .soft_rst0(soft_rst0), .soft_rst1(soft_rst1),
        .soft_rst2(soft_rst2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // compare every output against the model and the current inputs
    task automatic check_all(input string tag);
        logic [2:0] exp_wr;
        logic       exp_full;
        logic [2:0] ev, es;
        bit         f [3];
        f = '{f_0, f_1, f_2};
        exp_wr   = (wr_en_reg && m_addr < 3) ? 3'(1 << m_addr) : 3'b000;
        exp_full = (m_addr < 3) ? f[m_addr] : 1'b0;
        ev = {~e_2, ~e_1, ~e_0};
        es = {m_srst[2], m_srst[1], m_srst[0]};
        check({tag, ".wr_en"}, wr_en, exp_wr);
        check({tag, ".fifo_full"}, {2'b00, fifo_full}, {2'b00, exp_full});
        check({tag, ".valid"}, {valid_out_2, valid_out_1, valid_out_0}, ev);
        check({tag, ".soft_rst"}, {soft_rst2, soft_rst1, soft_rst0}, es);
    endtask

    // advance one edge: update model with the inputs present at that edge
    task automatic step(input string tag);
        bit e [3];
        bit re [3];
        bit hold;
        @(posedge clk);
        e  = '{e_0, e_1, e_2};
        re = '{re_0, re_1, re_2};
        if (rst) begin
            m_addr = 0;
            for (int n = 0; n < 3; n++) begin
                m_run[n]  = 0;
                m_srst[n] = 0;
            end
        end else begin
            if (det_addr) m_addr = int'(din);
            for (int n = 0; n < 3; n++) begin
                hold = !e[n] && !re[n];
                m_run[n]  = hold ? m_run[n] + 1 : 0;
                m_srst[n] = hold && (m_run[n] % 30 == 0);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic settle(input string tag);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1; wr_en_reg = 0; det_addr = 0; din = 2'b00;
        f_0 = 0; f_1 = 0; f_2 = 0; e_0 = 1; e_1 = 1; e_2 = 1;
        re_0 = 0; re_1 = 0; re_2 = 0;
        m_addr = 3;
        for (int n = 0; n < 3; n++) begin m_run[n] = 0; m_srst[n] = 0; end

        // reset state
        step("reset");
        step("reset2");
        check("reset_wr_en_lit", wr_en, 3'b000);
        wr_en_reg = 1;
        settle("reset_wr1");
        check("reset_wr_en_001", wr_en, 3'b001);
        rst = 0;

        // address capture and write steering
        det_addr = 1;
        for (int a = 0; a < 4; a++) begin
            din = 2'(a);
            step("addr_seq");
        end
        check("addr3_no_write", wr_en, 3'b000);
        wr_en_reg = 0;
        settle("wr_off");

        // full-flag mux
        din = 2'b10;
        step("addr2");
        f_2 = 1;
        settle("full_f2");
        check("full_f2_lit", {2'b00, fifo_full}, 3'b001);
        din = 2'b00; f_0 = 1; f_2 = 0;
        step("addr0_full");
        f_0 = 0;
        settle("addr0_notfull");
        din = 2'b11; f_0 = 1; f_1 = 1; f_2 = 1;
        step("addr3_full");
        check("addr3_full_lit", {2'b00, fifo_full}, 3'b000);
        f_0 = 0; f_1 = 0; f_2 = 0; det_addr = 0;

        // valid flags
        e_0 = 0; e_1 = 1; e_2 = 1; settle("valid_100");
        e_0 = 1; e_1 = 0;          settle("valid_010");
        e_1 = 1; e_2 = 0;          settle("valid_001");
        e_2 = 1;
        step("idle");

        // port 0 held for 35 edges
        e_0 = 0; re_0 = 0;
        for (int i = 1; i <= 35; i++) begin
            step("hold0");
            if (i == 30) check("hold0_pulse", {2'b00, soft_rst0}, 3'b001);
            if (i == 31) check("hold0_drop", {2'b00, soft_rst0}, 3'b000);
        end
        e_0 = 1;
        step("hold0_end");

        // read at cycle 20 restarts the window
        e_0 = 0;
        for (int i = 1; i <= 45; i++) begin
            re_0 = (i == 20);
            step("restart0");
            if (i == 30) check("restart0_nopulse", {2'b00, soft_rst0}, 3'b000);
        end
        e_0 = 1; re_0 = 0;
        step("restart0_end");

        // ports 0 and 2 time out together
        e_0 = 0; e_2 = 0;
        for (int i = 1; i <= 31; i++) begin
            step("hold02");
            if (i == 30) check("hold02_pulse", {soft_rst2, soft_rst1, soft_rst0}, 3'b101);
        end

        // reset mid-count clears timers
        for (int i = 0; i < 15; i++) step("pre_rst");
        rst = 1;
        step("mid_rst");
        rst = 0;
        for (int i = 1; i <= 31; i++) begin
            step("post_rst");
            if (i == 29) check("post_rst_nopulse", {soft_rst2, soft_rst1, soft_rst0}, 3'b000);
            if (i == 30) check("post_rst_pulse", {soft_rst2, soft_rst1, soft_rst0}, 3'b101);
        end
        e_0 = 1; e_2 = 1;
        step("pre_random");

        // random traffic, long holds made likely
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            wr_en_reg = 1'($urandom);
            det_addr  = ($urandom_range(0, 7) == 0);
            din       = 2'($urandom);
            f_0 = 1'($urandom); f_1 = 1'($urandom); f_2 = 1'($urandom);
            e_0 = ($urandom_range(0, 40) == 0);
            e_1 = ($urandom_range(0, 40) == 0);
            e_2 = ($urandom_range(0, 40) == 0);
            re_0 = ($urandom_range(0, 60) == 0);
            re_1 = ($urandom_range(0, 60) == 0);
            re_2 = ($urandom_range(0, 60) == 0);
            settle("rand_comb");
            step("rand_edge");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synchronizer.md
# synchronizer

Router control-path glue between the packet-routing FSM, the three output FIFOs and the three destination read ports. It captures the destination address of each incoming packet, steers the FSM's write strobe to the selected FIFO and returns that FIFO's full flag to the FSM. It also drives each port's valid flag and issues a per-port soft reset when a destination leaves its data unread for 30 cycles.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_en_reg  input  1  FSM write request for the current packet byte.
- wr_en  output  3  one-hot FIFO write enables (bit n → FIFO n).
- din  input  2  destination address field of the header byte.
- det_addr  input  1  FSM header-detect strobe; address capture enable.
- f_0, f_1, f_2  input  1 each  full flags of FIFO 0/1/2.
- e_0, e_1, e_2  input  1 each  empty flags of FIFO 0/1/2.
- re_0, re_1, re_2  input  1 each  read enables from destination ports 0/1/2.
- fifo_full  output  1  full flag of the currently addressed FIFO, to FSM.
- valid_out_0, valid_out_1, valid_out_2  output  1 each  data-available flag per port.
- soft_rst0, soft_rst1, soft_rst2  output  1 each  soft-reset pulse to FIFO 0/1/2.

## Operation
- Address register addr[1:0]: on rising edge with det_addr=1, addr ← din; otherwise holds.
- wr_en (combinational): if wr_en_reg=0 → 000; else addr 00→001, 01→010, 10→100, 11→000 (invalid address, no write).
- fifo_full (combinational): addr 00→f_0, 01→f_1, 10→f_2, 11→0.
- valid_out_n = ~e_n (combinational, all three ports independent of addr).
- Soft-reset timer, one per port n, 5-bit counter cnt_n:
  - Condition hold_n = valid_out_n & ~re_n.
  - hold_n=0 → cnt_n ← 0, soft_rstn ← 0.
  - hold_n=1 and cnt_n<29 → cnt_n ← cnt_n+1, soft_rstn ← 0.
  - hold_n=1 and cnt_n=29 → cnt_n ← 0, soft_rstn ← 1.
  - soft_rstn is a registered one-cycle pulse; if the port keeps holding, it reasserts every 30 cycles.
- Three ports fully independent; simultaneous timeouts on several ports assert their soft resets in the same cycle.
- Unknown/undriven full/empty/read inputs are the integrator's responsibility; no X-filtering.

## Timing
- Reset (rst=1 at rising edge): addr=00, cnt_0..2=0, soft_rst0..2=0. Consequently wr_en = 000 if wr_en_reg=0 else 001; fifo_full=f_0; valid_out follows empties immediately.
- rst has priority over det_addr and the timers.
- Address latency: din captured at the edge where det_addr=1; wr_en/fifo_full reflect the new address from that edge onward (zero-cycle combinational after the register).
- det_addr and wr_en_reg asserted together: wr_en in the cycle before the edge uses the old addr, after the edge the new addr.
- wr_en and fifo_full change combinationally with wr_en_reg and f_n within a cycle.
- Soft reset: hold_n continuously true at 30 consecutive rising edges → soft_rstn high after the 30th edge, low after the 31st.
- Any single cycle of re_n=1 or e_n=1 restarts the 30-cycle window.

## Test plan
- Reset with wr_en_reg=0 → wr_en=000, soft_rst0..2=0, addr=00; then wr_en_reg=1 → wr_en=001.
- wr_en_reg=1, det_addr=1, din=00/01/10/11 on successive edges → wr_en=001, 010, 100, 000 after each edge; wr_en_reg=0 → 000.
- addr=10, f_0=0,f_1=0,f_2=1 → fifo_full=1; latch din=00 with f_0=1,f_2=0 → fifo_full=1; f_0=0 → 0; addr=11 with all full → 0.
- e_0=0,e_1=1,e_2=1 → valid_out=1,0,0; e_0=1,e_1=0 → 0,1,0; e_2=0 only → 0,0,1.
- e_0=0, re_0=0 for 35 cycles → soft_rst0 high for exactly one cycle after 30th edge, others stay 0; re_0=1 at cycle 20 → no pulse, window restarts.
- Port 0 and port 2 holding from same edge → soft_rst0 and soft_rst2 pulse in same cycle; rst asserted mid-count → counters clear, no pulse until 30 fresh cycles.
